// File: rtl/ps2_digit_entry_buffer.sv
// Hex number entry buffer driven by decoded PS/2 key events.
// Keeps a live edit buffer and a committed display buffer that changes only on enter.
module ps2_digit_entry_buffer #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned OVF_MODE = 0,
  parameter int unsigned FRESH    = 1,
  localparam int unsigned CW      = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [1:0]            key_type,
  input  logic [3:0]            key_code,
  output logic [4*DIGITS-1:0]   edit_numb,
  output logic [DIGITS-1:0]     edit_mask,
  output logic [4*DIGITS-1:0]   disp_numb,
  output logic [DIGITS-1:0]     disp_mask,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  commit_pulse,
  output logic                  ovf_pulse
);

  typedef enum logic [1:0] {S_EMPTY, S_EDIT, S_FULL, S_DONE} state_t;
  typedef enum logic [1:0] {K_DIGIT, K_ENTER, K_BACK, K_CLEAR} key_t;

  localparam logic [CW-1:0] FULL_CNT = CW'(DIGITS);

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   numb_q, numb_d;
  logic [DIGITS-1:0]     mask_q, mask_d;
  logic [4*DIGITS-1:0]   dnumb_q, dnumb_d;
  logic [DIGITS-1:0]     dmask_q, dmask_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  commit_q, commit_d;
  logic                  ovf_q, ovf_d;

  function automatic state_t state_for(input logic [CW-1:0] c);
    if (c == '0)            return S_EMPTY;
    else if (c == FULL_CNT) return S_FULL;
    else                    return S_EDIT;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_EMPTY;
      numb_q   <= '0;
      mask_q   <= '1;
      dnumb_q  <= '0;
      dmask_q  <= '1;
      cnt_q    <= '0;
      commit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      numb_q   <= numb_d;
      mask_q   <= mask_d;
      dnumb_q  <= dnumb_d;
      dmask_q  <= dmask_d;
      cnt_q    <= cnt_d;
      commit_q <= commit_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    numb_d   = numb_q;
    mask_d   = mask_q;
    dnumb_d  = dnumb_q;
    dmask_d  = dmask_q;
    cnt_d    = cnt_q;
    commit_d = 1'b0;
    ovf_d    = 1'b0;
    if (key_valid) begin
      unique case (key_t'(key_type))
        K_DIGIT: begin
          if (state_q == S_DONE && FRESH != 0) begin
            numb_d = {{(4*DIGITS-4){1'b0}}, key_code};
            mask_d = {{(DIGITS-1){1'b1}}, 1'b0};
            cnt_d  = CW'(1);
          end else if (cnt_q == FULL_CNT) begin
            // DONE without FRESH lands here too when the buffer is full
            ovf_d = 1'b1;
            if (OVF_MODE == 0) begin
              numb_d = {numb_q[4*DIGITS-5:0], key_code};
              mask_d = {mask_q[DIGITS-2:0], 1'b0};
            end
          end else begin
            numb_d = {numb_q[4*DIGITS-5:0], key_code};
            mask_d = {mask_q[DIGITS-2:0], 1'b0};
            cnt_d  = cnt_q + CW'(1);
          end
          state_d = state_for(cnt_d);
        end
        K_ENTER: begin
          dnumb_d  = numb_q;
          dmask_d  = mask_q;
          commit_d = 1'b1;
          state_d  = S_DONE;
        end
        K_BACK: begin
          if (cnt_q != '0) begin
            numb_d = {4'h0, numb_q[4*DIGITS-1:4]};
            mask_d = {1'b1, mask_q[DIGITS-1:1]};
            cnt_d  = cnt_q - CW'(1);
          end
          state_d = state_for(cnt_d);
        end
        K_CLEAR: begin
          numb_d  = '0;
          mask_d  = '1;
          cnt_d   = '0;
          state_d = S_EMPTY;
        end
        default: ;
      endcase
    end
  end

  assign edit_numb    = numb_q;
  assign edit_mask    = mask_q;
  assign disp_numb    = dnumb_q;
  assign disp_mask    = dmask_q;
  assign count        = cnt_q;
  assign full         = (cnt_q == FULL_CNT);
  assign commit_pulse = commit_q;
  assign ovf_pulse    = ovf_q;

endmodule
